sram_arbiter: RTL and testbench

- Sequences all accesses to the external 1Mx16 SRAM and shares it between two requesters: port 0 (CPU MAR/MDR path) and port 1 (debug/program loader).
- Generates the active-low CE/OE/WE/UB/LB strobes, the address, and the tristate write-drive enable, with a configurable number of access wait states.
- Sits between the CPU datapath/ISDU and the tristate buffer plus Mem2IO layer. Replaces the fixed-timing memory strobes currently driven directly by the ISDU.

---
 rtl/sram_arb_pkg.sv | 34 +++
 rtl/sram_arbiter_if.sv | 57 +++++
 rtl/sram_arbiter_arb_pick.sv | 41 ++++
 rtl/sram_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the external SRAM arbiter:
//               FSM state encoding, requester port indices and the latched
//               request record.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    // Geometry of the external 1Mx16 SRAM; the request record is sized to it.
    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    // Requester port indices
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic               we;
        logic [1:0]         be;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Bundle of the two requester ports and the SRAM-side strobes,
//               address and data paths of the SRAM arbiter.
//               slave  : arbiter view
//               master : requesters + tristate/Mem2IO view
// Ports       : p0_*/p1_* req/we/be/addr/wdata in, p0_ack/p1_ack out,
//               rdata/grant_id/busy out, CE/OE/WE/UB/LB/ADDR/Data_Mem_Out/
//               mem_drive out, Data_Mem_In in (directions from slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic          p0_req;
    logic          p1_req;
    logic          p0_we;
    logic          p1_we;
    logic [1:0]    p0_be;
    logic [1:0]    p1_be;
    logic [AW-1:0] p0_addr;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p0_wdata;
    logic [DW-1:0] p1_wdata;
    logic          p0_ack;
    logic          p1_ack;
    logic [DW-1:0] rdata;
    logic          grant_id;
    logic          busy;
    logic          CE;
    logic          OE;
    logic          WE;
    logic          UB;
    logic          LB;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] Data_Mem_Out;
    logic [DW-1:0] Data_Mem_In;
    logic          mem_drive;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_be, p1_be,
               p0_addr, p1_addr, p0_wdata, p1_wdata, Data_Mem_In,
        output p0_ack, p1_ack, rdata, grant_id, busy,
               CE, OE, WE, UB, LB, ADDR, Data_Mem_Out, mem_drive
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_be, p1_be,
               p0_addr, p1_addr, p0_wdata, p1_wdata, Data_Mem_In,
        input  p0_ack, p1_ack, rdata, grant_id, busy,
               CE, OE, WE, UB, LB, ADDR, Data_Mem_Out, mem_drive
    );

endinterface
`default_nettype wire

// File: rtl/sram_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner selection between the CPU port (0) and
//               the debug/loader port (1).
//               Optional macro SRAM_ARB_ROUND_ROBIN_EN: a tie goes to the port
//               named by i_rr_ptr; otherwise port 0 always wins a tie.
// Ports       : i_req0, i_req1  - requests
//               i_rr_ptr        - preferred port on a tie (macro builds only)
//               o_any           - at least one request present
//               o_winner        - index of the winning port
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import sram_arb_pkg::*;
(
    input  wire logic i_req0,
    input  wire logic i_req1,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    input  wire logic i_rr_ptr,
`endif
    output logic      o_any,
    output logic      o_winner
);

    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = PORT_CPU;
        if (i_req0 && i_req1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            o_winner = i_rr_ptr;
`else
            o_winner = PORT_CPU;
`endif
        end else if (i_req1) begin
            o_winner = PORT_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Sequences every access to the external 1Mx16 SRAM and shares
//               it between the CPU port (0) and the debug/loader port (1).
//               Transfer: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE -> IDLE.
//               All SRAM strobes are registered and active low.
//               Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin tie break
//               (default build: fixed port-0 priority).
// Ports       : Clk, Reset (sync, active high)
//               bus - sram_arbiter_if.slave (requesters + SRAM side)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 20,
    parameter int DW          = 16
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    sram_arbiter_if.slave bus
);
    import sram_arb_pkg::*;

    localparam int c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYCLES must be at least 1");
    end
    // The request record is sized for the 1Mx16 part.
    if (AW != SRAM_AW || DW != SRAM_DW) begin : g_bad_geometry
        $error("sram_arbiter: AW/DW must match the SRAM geometry in sram_arb_pkg");
    end

    arb_state_t           r_state;
    arb_state_t           w_state_nx;
    mem_req_t             r_req;
    mem_req_t             w_req_nx;
    logic                 r_grant;
    logic                 w_grant_nx;
    logic [c_cnt_w-1:0]   r_wait;
    logic                 w_any;
    logic                 w_winner;
    logic                 w_take;
    logic [DW-1:0]        r_rdata;

    logic w_ce_nx, w_oe_nx, w_we_nx, w_ub_nx, w_lb_nx, w_drive_nx;
    logic w_ack0_nx, w_ack1_nx;
    logic r_ce, r_oe, r_we, r_ub, r_lb, r_drive, r_ack0, r_ack1;

    // A new transfer is accepted only from IDLE.
    assign w_take = (r_state == ST_IDLE) && w_any;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Port preferred on the next tie: the one not granted last.
    logic r_rr_ptr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr <= PORT_CPU;
        end else if (w_take) begin
            r_rr_ptr <= ~w_winner;
        end
    end
`endif

    arb_pick u_arb_pick (
        .i_req0   (bus.p0_req),
        .i_req1   (bus.p1_req),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        .i_rr_ptr (r_rr_ptr),
`endif
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_state_nx = ST_SETUP;
            ST_SETUP:  w_state_nx = ST_ACCESS;
            ST_ACCESS: if (r_wait == '0) w_state_nx = ST_DONE;
            ST_DONE:   w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // Registered strobes are computed from the state being entered so that
    // they line up with that state's cycle.
    always_comb begin
        w_ce_nx    = 1'b1;
        w_oe_nx    = 1'b1;
        w_we_nx    = 1'b1;
        w_ub_nx    = 1'b1;
        w_lb_nx    = 1'b1;
        w_drive_nx = 1'b0;
        w_ack0_nx  = 1'b0;
        w_ack1_nx  = 1'b0;
        if (w_state_nx != ST_IDLE) begin
            // SETUP, ACCESS and DONE share CE/OE/UB/LB/drive; DONE is the hold cycle.
            w_ce_nx    = 1'b0;
            w_ub_nx    = ~w_req_nx.be[1];
            w_lb_nx    = ~w_req_nx.be[0];
            w_oe_nx    = w_req_nx.we;
            w_drive_nx = w_req_nx.we;
        end
        if (w_state_nx == ST_ACCESS) begin
            w_we_nx = ~w_req_nx.we;
        end
        if (w_state_nx == ST_DONE) begin
            w_ack0_nx = (w_grant_nx == PORT_CPU);
            w_ack1_nx = (w_grant_nx == PORT_DBG);
        end
    end

    // ------------------------------------------------------ request latch
    always_comb begin
        w_req_nx   = r_req;
        w_grant_nx = r_grant;
        if (w_take) begin
            w_grant_nx = w_winner;
            if (w_winner == PORT_DBG) begin
                w_req_nx = '{we: bus.p1_we, be: bus.p1_be, addr: bus.p1_addr, wdata: bus.p1_wdata};
            end else begin
                w_req_nx = '{we: bus.p0_we, be: bus.p0_be, addr: bus.p0_addr, wdata: bus.p0_wdata};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_req   <= '0;
            r_grant <= PORT_CPU;
        end else begin
            r_req   <= w_req_nx;
            r_grant <= w_grant_nx;
        end
    end

    // Counter is loaded in SETUP and counts the remaining ACCESS cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait <= c_wait_load;
        end else if (r_state == ST_ACCESS && r_wait != '0) begin
            r_wait <= r_wait - c_cnt_w'(1);
        end
    end

    // Read data is taken on the last ACCESS edge; writes leave it alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rdata <= '0;
        end else if (r_state == ST_ACCESS && r_wait == '0 && !r_req.we) begin
            r_rdata <= bus.Data_Mem_In;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_ub    <= 1'b1;
            r_lb    <= 1'b1;
            r_drive <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ce    <= w_ce_nx;
            r_oe    <= w_oe_nx;
            r_we    <= w_we_nx;
            r_ub    <= w_ub_nx;
            r_lb    <= w_lb_nx;
            r_drive <= w_drive_nx;
            r_ack0  <= w_ack0_nx;
            r_ack1  <= w_ack1_nx;
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.CE           = r_ce;
    assign bus.OE           = r_oe;
    assign bus.WE           = r_we;
    assign bus.UB           = r_ub;
    assign bus.LB           = r_lb;
    assign bus.mem_drive    = r_drive;
    assign bus.p0_ack       = r_ack0;
    assign bus.p1_ack       = r_ack1;
    assign bus.ADDR         = r_req.addr;
    assign bus.Data_Mem_Out = r_req.wdata;
    assign bus.rdata        = r_rdata;
    assign bus.grant_id     = r_grant;
    assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter. Cycle 1 is the
//               first cycle after the edge that samples a request in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.AW(20), .DW(16)) bus  ();
    sram_arbiter_if #(.AW(20), .DW(16)) bus1 ();
    sram_arbiter_if #(.AW(20), .DW(16)) bus5 ();

    sram_arbiter #(.WAIT_CYCLES(2), .AW(20), .DW(16)) dut  (.Clk(clk), .Reset(rst), .bus(bus));
    sram_arbiter #(.WAIT_CYCLES(1), .AW(20), .DW(16)) dut1 (.Clk(clk), .Reset(rst), .bus(bus1));
    sram_arbiter #(.WAIT_CYCLES(5), .AW(20), .DW(16)) dut5 (.Clk(clk), .Reset(rst), .bus(bus5));

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- SRAM model: read while CE/OE low, write commits when WE rises
    logic [15:0] mem [0:1023];
    int          n_writes = 0;
    logic        pend = 1'b0;
    logic [9:0]  pend_addr;
    logic [15:0] pend_data;
    logic [1:0]  pend_be;

    assign bus.Data_Mem_In  = (!bus.CE && !bus.OE) ? mem[bus.ADDR[9:0]] : 16'h0000;
    assign bus1.Data_Mem_In = 16'hC0DE;
    assign bus5.Data_Mem_In = 16'hC0DE;

    always @(negedge clk) begin
        if (!bus.CE && !bus.WE) begin
            pend      = 1'b1;
            pend_addr = bus.ADDR[9:0];
            pend_data = bus.Data_Mem_Out;
            pend_be   = ~{bus.UB, bus.LB};
        end else if (pend) begin
            if (!bus.CE) begin
                if (pend_be[1]) mem[pend_addr][15:8] = pend_data[15:8];
                if (pend_be[0]) mem[pend_addr][7:0]  = pend_data[7:0];
                n_writes = n_writes + 1;
            end
            pend = 1'b0;
        end
    end

    // ---------------- per-cycle trace, bit k = cycle k
    logic [16:1] tr_ce, tr_oe, tr_we, tr_ub, tr_lb, tr_drv, tr_ack0, tr_ack1, tr_busy;
    logic [15:0] tr_rdata [1:16];
    logic        tr_gid   [1:16];
    int          need0, need1;

    function automatic logic [16:1] m(input int lo, input int hi);
        logic [16:1] r;
        r = '0;
        for (int k = 1; k <= 16; k++) if (k >= lo && k <= hi) r[k] = 1'b1;
        return r;
    endfunction

    // Records n cycles; each requester drops req in the ack cycle of its last transfer.
    task automatic run_trace(input int n);
        tr_ce = '0; tr_oe = '0; tr_we = '0; tr_ub = '0; tr_lb = '0;
        tr_drv = '0; tr_ack0 = '0; tr_ack1 = '0; tr_busy = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            tr_ce[i]    = bus.CE;
            tr_oe[i]    = bus.OE;
            tr_we[i]    = bus.WE;
            tr_ub[i]    = bus.UB;
            tr_lb[i]    = bus.LB;
            tr_drv[i]   = bus.mem_drive;
            tr_ack0[i]  = bus.p0_ack;
            tr_ack1[i]  = bus.p1_ack;
            tr_busy[i]  = bus.busy;
            tr_rdata[i] = bus.rdata;
            tr_gid[i]   = bus.grant_id;
            if (bus.p0_ack) begin need0--; if (need0 <= 0) bus.p0_req = 1'b0; end
            if (bus.p1_ack) begin need1--; if (need1 <= 0) bus.p1_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.CE, bus.OE, bus.WE, bus.UB, bus.LB} !== 5'b11111) begin
            n_fail++; $display("FAIL reset_strobes got %b want 11111", {bus.CE, bus.OE, bus.WE, bus.UB, bus.LB});
        end
        n_tests++;
        if ({bus.ADDR, bus.Data_Mem_Out, bus.rdata} !== 52'h0) begin
            n_fail++; $display("FAIL reset_data got addr=%h dout=%h rdata=%h want 0", bus.ADDR, bus.Data_Mem_Out, bus.rdata);
        end
        n_tests++;
        if ({bus.p0_ack, bus.p1_ack, bus.mem_drive, bus.grant_id, bus.busy} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000", {bus.p0_ack, bus.p1_ack, bus.mem_drive, bus.grant_id, bus.busy});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        mem[10'h123] = 16'hBEEF;
        bus.p0_we = 1'b0; bus.p0_be = 2'b11; bus.p0_addr = 20'h00123; bus.p0_wdata = 16'h0000;
        bus.p0_req = 1'b1; need0 = 1;
        run_trace(6);
        n_tests++;
        if (tr_oe[6:1] !== m(5, 6) || tr_ce[6:1] !== m(5, 6)) begin
            n_fail++; $display("FAIL read_oe_ce got oe=%b ce=%b want %b", tr_oe[6:1], tr_ce[6:1], m(5, 6));
        end
        n_tests++;
        if (tr_we[6:1] !== m(1, 6) || tr_drv[6:1] !== '0) begin
            n_fail++; $display("FAIL read_we_drv got we=%b drv=%b want we=111111 drv=000000", tr_we[6:1], tr_drv[6:1]);
        end
        n_tests++;
        if (tr_ack0 !== m(4, 4) || tr_ack1 !== '0) begin
            n_fail++; $display("FAIL read_ack got ack0=%b ack1=%b want ack0=%b", tr_ack0, tr_ack1, m(4, 4));
        end
        n_tests++;
        if (tr_rdata[4] !== 16'hBEEF || tr_rdata[6] !== 16'hBEEF) begin
            n_fail++; $display("FAIL read_rdata got c4=%h c6=%h want beef", tr_rdata[4], tr_rdata[6]);
        end
        n_tests++;
        if (tr_busy[6:1] !== m(1, 4) || tr_gid[1] !== 1'b0) begin
            n_fail++; $display("FAIL read_busy got busy=%b gid=%b want %b gid=0", tr_busy[6:1], tr_gid[1], m(1, 4));
        end
    endtask

    task automatic test_write_be();
        mem[10'h010] = 16'hFFFF;
        bus.p1_we = 1'b1; bus.p1_be = 2'b01; bus.p1_addr = 20'h00010; bus.p1_wdata = 16'h5A5A;
        bus.p1_req = 1'b1; need1 = 1;
        run_trace(6);
        n_tests++;
        if (tr_ub[6:1] !== m(1, 6) || tr_lb[6:1] !== m(5, 6)) begin
            n_fail++; $display("FAIL write_ub_lb got ub=%b lb=%b want ub=%b lb=%b", tr_ub[6:1], tr_lb[6:1], m(1, 6), m(5, 6));
        end
        n_tests++;
        if (tr_we[6:1] !== (m(1, 1) | m(4, 6))) begin
            n_fail++; $display("FAIL write_we got %b want %b", tr_we[6:1], m(1, 1) | m(4, 6));
        end
        n_tests++;
        if (tr_drv[6:1] !== m(1, 4) || tr_oe[6:1] !== m(1, 6)) begin
            n_fail++; $display("FAIL write_drv_oe got drv=%b oe=%b want drv=%b oe=111111", tr_drv[6:1], tr_oe[6:1], m(1, 4));
        end
        n_tests++;
        if (tr_ack1 !== m(4, 4) || tr_ack0 !== '0 || tr_gid[1] !== 1'b1) begin
            n_fail++; $display("FAIL write_ack got ack1=%b ack0=%b gid=%b want ack1=%b gid=1", tr_ack1, tr_ack0, tr_gid[1], m(4, 4));
        end
        n_tests++;
        if (mem[10'h010] !== 16'hFF5A || tr_rdata[6] !== 16'hBEEF) begin
            n_fail++; $display("FAIL write_data got mem=%h rdata=%h want mem=ff5a rdata=beef", mem[10'h010], tr_rdata[6]);
        end
    endtask

    task automatic test_reset_mid();
        int wcount;
        mem[10'h200] = 16'h1111;
        wcount = n_writes;
        bus.p0_we = 1'b1; bus.p0_be = 2'b11; bus.p0_addr = 20'h00200; bus.p0_wdata = 16'hABCD;
        bus.p0_req = 1'b1;
        @(negedge clk);              // SETUP
        @(negedge clk);              // first ACCESS
        n_tests++;
        if (bus.WE !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_access got WE=%b want 0", bus.WE);
        end
        rst = 1'b1; bus.p0_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.CE, bus.OE, bus.WE, bus.UB, bus.LB, bus.busy, bus.mem_drive} !== 7'b1111100) begin
            n_fail++; $display("FAIL rstmid_strobes got %b want 1111100", {bus.CE, bus.OE, bus.WE, bus.UB, bus.LB, bus.busy, bus.mem_drive});
        end
        n_tests++;
        if (bus.rdata !== 16'h0000 || bus.p0_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_rdata got rdata=%h ack=%b want 0", bus.rdata, bus.p0_ack);
        end
        rst = 1'b0; need0 = 0; need1 = 0;
        run_trace(4);
        n_tests++;
        if ((tr_ack0 | tr_ack1 | tr_busy) !== '0) begin
            n_fail++; $display("FAIL rstmid_noack got ack0=%b ack1=%b busy=%b want 0", tr_ack0, tr_ack1, tr_busy);
        end
        n_tests++;
        if (mem[10'h200] !== 16'h1111 || n_writes !== wcount) begin
            n_fail++; $display("FAIL rstmid_nowrite got mem=%h writes=%0d want 1111 %0d", mem[10'h200], n_writes, wcount);
        end
    endtask

    // Port 0 wants two transfers, port 1 one; one transfer plus the IDLE cycle is 5 cycles.
    task automatic test_tie();
        logic [16:1] e0, e1;
        logic [15:0] d9, d14;
        logic        g6;
        bus.p0_we = 1'b0; bus.p0_be = 2'b11; bus.p0_addr = 20'h00123;
        bus.p1_we = 1'b0; bus.p1_be = 2'b11; bus.p1_addr = 20'h00010;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1; need0 = 2; need1 = 1;
        run_trace(15);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        e0 = m(4, 4) | m(14, 14); e1 = m(9, 9);  g6 = 1'b1; d9 = 16'hFF5A; d14 = 16'hBEEF;
`else
        e0 = m(4, 4) | m(9, 9);   e1 = m(14, 14); g6 = 1'b0; d9 = 16'hBEEF; d14 = 16'hFF5A;
`endif
        n_tests++;
        if (tr_ack0 !== e0 || tr_ack1 !== e1) begin
            n_fail++; $display("FAIL tie_acks got ack0=%b ack1=%b want ack0=%b ack1=%b", tr_ack0, tr_ack1, e0, e1);
        end
        n_tests++;
        if (tr_gid[1] !== 1'b0 || tr_gid[6] !== g6) begin
            n_fail++; $display("FAIL tie_grant got c1=%b c6=%b want c1=0 c6=%b", tr_gid[1], tr_gid[6], g6);
        end
        n_tests++;
        if (tr_rdata[4] !== 16'hBEEF || tr_rdata[9] !== d9 || tr_rdata[14] !== d14) begin
            n_fail++; $display("FAIL tie_rdata got %h %h %h want beef %h %h", tr_rdata[4], tr_rdata[9], tr_rdata[14], d9, d14);
        end
    endtask

    task automatic test_back_to_back();
        bus.p0_we = 1'b0; bus.p0_be = 2'b11; bus.p0_addr = 20'h00123;
        bus.p0_req = 1'b1; need0 = 2;
        run_trace(11);
        n_tests++;
        if (tr_ack0 !== (m(4, 4) | m(9, 9)) || tr_ack1 !== '0) begin
            n_fail++; $display("FAIL b2b_acks got ack0=%b ack1=%b want ack0=%b", tr_ack0, tr_ack1, m(4, 4) | m(9, 9));
        end
        n_tests++;
        if (tr_busy !== (m(1, 4) | m(6, 9))) begin
            n_fail++; $display("FAIL b2b_busy got %b want %b", tr_busy, m(1, 4) | m(6, 9));
        end
    endtask

    task automatic test_param_sweep();
        int lat;
        bus1.p0_req = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus1.p0_ack && lat < 20);
        bus1.p0_req = 1'b0;
        n_tests++;
        if (lat !== 3 || bus1.rdata !== 16'hC0DE) begin
            n_fail++; $display("FAIL sweep_w1 got latency=%0d rdata=%h want 3 c0de", lat, bus1.rdata);
        end
        repeat (2) @(negedge clk);
        bus5.p0_req = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus5.p0_ack && lat < 20);
        bus5.p0_req = 1'b0;
        n_tests++;
        if (lat !== 7 || bus5.rdata !== 16'hC0DE) begin
            n_fail++; $display("FAIL sweep_w5 got latency=%0d rdata=%h want 7 c0de", lat, bus5.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_be = 2'b00; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_be = 2'b00; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus1.p0_req = 1'b0; bus1.p0_we = 1'b0; bus1.p0_be = 2'b11; bus1.p0_addr = 20'h00042; bus1.p0_wdata = '0;
        bus1.p1_req = 1'b0; bus1.p1_we = 1'b0; bus1.p1_be = 2'b00; bus1.p1_addr = '0; bus1.p1_wdata = '0;
        bus5.p0_req = 1'b0; bus5.p0_we = 1'b0; bus5.p0_be = 2'b11; bus5.p0_addr = 20'h00042; bus5.p0_wdata = '0;
        bus5.p1_req = 1'b0; bus5.p1_we = 1'b0; bus5.p1_be = 2'b00; bus5.p1_addr = '0; bus5.p1_wdata = '0;
        need0 = 0; need1 = 0;

        test_reset();
        test_single_read();
        test_write_be();
        test_reset_mid();
        test_tie();
        test_back_to_back();
        test_param_sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
